// File: rtl/sam_seq_pkg.sv
// Shared constants and types for the sample-RAM sequencer.
// Opcode values, instruction field offsets, default widths, FSM states.
package sam_seq_pkg;

    localparam int SEQ_ADDR_W = 10;
    localparam int SEQ_DATA_W = 16;

    localparam logic [1:0] OP_NOP      = 2'b00;
    localparam logic [1:0] OP_WRITE    = 2'b01;
    localparam logic [1:0] OP_SETRANGE = 2'b10;
    localparam logic [1:0] OP_GO       = 2'b11;

    localparam int OP_LSB       = 30;
    localparam int WR_ADDR_LSB  = 16;
    localparam int WR_DATA_LSB  = 0;
    localparam int SR_START_LSB = 10;
    localparam int SR_END_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/sam_out_buffer.sv
// Two-entry FIFO for stream outputs; head is visible while count != 0.
// Ports: clk, rst (sync, high), push/push_data, pop, head, count.
module sam_out_buffer #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sam_mem_sequencer.sv
// Instruction-driven controller for a single-port sample RAM: writes,
// range setup and read bursts streamed out with valid/ready and last.
// Ports: clk, rst; in_* instruction stream; out_* burst stream;
//        ram_* RAM interface (1-cycle read latency); busy.
module sam_mem_sequencer
    import sam_seq_pkg::*;
#(
    parameter int ADDR_W = SEQ_ADDR_W,
    parameter int DATA_W = SEQ_DATA_W,
    parameter int IN_W   = 32,
    parameter int OUT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_en,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    localparam int BUF_W = DATA_W + 1;
    localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

    state_t state;
    state_t state_nx;

    logic [1:0]        op;
    logic              accept;
    logic              issue;
    logic              pop;
    logic              room;
    logic [2:0]        occ_after;

    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] range_start_q;
    logic [ADDR_W-1:0] range_end_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W:0]   remaining_q;
    logic              inflight_q;
    logic              inflight_last_q;

    logic              buf_push;
    logic              buf_pop;
    logic [BUF_W-1:0]  buf_head;
    logic [1:0]        buf_count;
    logic [BUF_W-1:0]  sel;

    logic              unused_bits;

    assign unused_bits = ^{in_last, in_data[29:26]};

    assign op     = in_data[OP_LSB +: 2];
    assign accept = in_valid && (state == ST_IDLE);
    assign span   = range_end_q - range_start_q;

    // The word in flight from the RAM is exposed directly, so the
    // first word is visible one cycle after its read is issued.
    assign out_valid = (buf_count != 2'd0) || inflight_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        sel = '0;
        if (buf_count != 2'd0) begin
            sel = buf_head;
        end else if (inflight_q) begin
            sel = {inflight_last_q, ram_dout};
        end
    end

    assign out_last = sel[DATA_W];
    assign out_data = {{(OUT_W-DATA_W){1'b0}}, sel[DATA_W-1:0]};

    // Only park the returning word when it is not consumed straight away.
    assign buf_push = inflight_q && !(pop && (buf_count == 2'd0));
    assign buf_pop  = pop && (buf_count != 2'd0);

    // Words held or in flight after this cycle's pop must leave a slot.
    assign occ_after = {1'b0, buf_count} + {2'b00, inflight_q}
                     - {2'b00, pop};
    assign room      = occ_after < 3'd2;

    sam_out_buffer #(
        .W (BUF_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data ({inflight_last_q, ram_dout}),
        .pop       (buf_pop),
        .head      (buf_head),
        .count     (buf_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        busy     = 1'b0;
        issue    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (op == OP_WRITE) begin
                        state_nx = ST_WRITE;
                    end else if (op == OP_GO) begin
                        state_nx = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                ram_we   = 1'b1;
                ram_addr = wr_addr_q;
                ram_din  = wr_data_q;
                state_nx = ST_IDLE;
            end
            ST_READ: begin
                busy = 1'b1;
                if (room) begin
                    issue    = 1'b1;
                    ram_en   = 1'b1;
                    ram_addr = rd_ptr_q;
                    if (remaining_q == REM_ONE) begin
                        state_nx = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (pop && out_last) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            range_start_q   <= '0;
            range_end_q     <= '0;
            rd_ptr_q        <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            if (accept && (op == OP_WRITE)) begin
                wr_addr_q <= in_data[WR_ADDR_LSB +: ADDR_W];
                wr_data_q <= in_data[WR_DATA_LSB +: DATA_W];
            end
            if (accept && (op == OP_SETRANGE)) begin
                range_start_q <= in_data[SR_START_LSB +: ADDR_W];
                range_end_q   <= in_data[SR_END_LSB +: ADDR_W];
            end
            // One extra bit so a full-memory range counts 1024.
            if (accept && (op == OP_GO)) begin
                rd_ptr_q    <= range_start_q;
                remaining_q <= {1'b0, span} + REM_ONE;
            end
            if (issue) begin
                rd_ptr_q    <= rd_ptr_q + ADDR_W'(1);
                remaining_q <= remaining_q - REM_ONE;
            end
            inflight_q      <= issue;
            inflight_last_q <= issue && (remaining_q == REM_ONE);
        end
    end

endmodule

// File: tb/tb_sam_mem_sequencer.sv
// Self-checking bench for sam_mem_sequencer with a behavioural RAM
// and a reference model of memory contents and the active range.
module tb_sam_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [9:0]  ram_addr;
    logic [15:0] ram_din;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_dout = '0;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int writes_sent = 0;
    int we_cnt = 0;
    int r_start = 0;
    int r_end   = 0;

    logic [15:0] ram     [1024];
    logic [15:0] ref_mem [1024];

    sam_mem_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        if (ram_en) ram_dout <= ram[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) we_cnt++;
            chk("en_we_excl", {31'b0, ram_en & ram_we}, 0);
        end
    end

    function automatic logic [31:0] mk_write(input logic [9:0] a,
                                             input logic [15:0] d);
        logic [31:0] r;
        r = $urandom;
        return {2'b01, r[3:0], a, d};
    endfunction

    function automatic logic [31:0] mk_range(input logic [9:0] s,
                                             input logic [9:0] e);
        logic [31:0] r;
        r = $urandom;
        return {2'b10, r[9:0], s, e};
    endfunction

    function automatic logic [31:0] mk_go();
        logic [31:0] r;
        r = $urandom;
        return {2'b11, r[29:0]};
    endfunction

    function automatic logic [31:0] mk_nop();
        logic [31:0] r;
        r = $urandom;
        return {2'b00, r[29:0]};
    endfunction

    // Called at +1 after an edge; returns at +1 after the accept edge
    // (or after the write cycle for WRITE).
    task automatic send(input logic [31:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 64) begin
            @(posedge clk); #2;
            n++;
        end
        chk("in_ready_wait", {31'b0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        if (w[31:30] == 2'b01) begin
            ref_mem[w[25:16]] = w[15:0];
            writes_sent++;
            #1;
            chk("wr_we", {31'b0, ram_we}, 1);
            chk("wr_addr", {22'b0, ram_addr}, {22'b0, w[25:16]});
            chk("wr_din", {16'b0, ram_din}, {16'b0, w[15:0]});
            @(posedge clk); #1;
        end else if (w[31:30] == 2'b10) begin
            r_start = int'(w[19:10]);
            r_end   = int'(w[9:0]);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, {31'b0, out_last}, 0);
        chk({tag, "_ram_en"}, {31'b0, ram_en}, 0);
        chk({tag, "_ram_we"}, {31'b0, ram_we}, 0);
        chk({tag, "_ram_addr"}, {22'b0, ram_addr}, 0);
        chk({tag, "_ram_din"}, {16'b0, ram_din}, 0);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 1);
    endtask

    // Starts in the cycle after GO was accepted (cycle index 0).
    // mode 0: ready held, 1: ready 1,0,0 pattern, 2: random ready.
    task automatic burst(input int mode, input int stop_after,
                         input bit hold_valid);
        int len, start, k, issued, c, first_valid, last_pop, budget;
        logic        pv;
        logic [31:0] pd;
        logic        pl;
        k = 0; issued = 0; c = 0;
        first_valid = -1; last_pop = -1;
        pv = 1'b0; pd = '0; pl = 1'b0;
        start  = r_start;
        len    = (((r_end - r_start) % 1024) + 1024) % 1024 + 1;
        budget = len * 4 + 40;
        if (hold_valid) begin
            in_valid = 1'b1;
            in_data  = mk_nop();
        end
        while (k < len && c < budget) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (c == 0) chk("first_issue", {31'b0, ram_en}, 1);
            if (pv) begin
                chk("hold_valid", {31'b0, out_valid}, 1);
                chk("hold_data", out_data, pd);
                chk("hold_last", {31'b0, out_last}, {31'b0, pl});
            end
            if (out_valid && first_valid < 0) first_valid = c;
            if (ram_en) begin
                chk("rd_addr", {22'b0, ram_addr}, (start + issued) % 1024);
                issued++;
            end
            if (out_valid && out_ready) begin
                chk("data", out_data,
                    {16'h0, ref_mem[(start + k) % 1024]});
                chk("last", {31'b0, out_last}, {31'b0, k == len - 1});
                k++;
                last_pop = c;
            end
            chk("outstanding", {31'b0, (issued - k) <= 2}, 1);
            chk("overissue", {31'b0, issued <= len}, 1);
            if (hold_valid) chk("in_ready_busy", {31'b0, in_ready}, 0);
            pv = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            c++;
            if (stop_after > 0 && k == stop_after) begin
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        chk("burst_count", k, len);
        if (mode == 0) begin
            chk("first_valid_lat", first_valid, 1);
            chk("last_pop_lat", last_pop, len);
        end
        #1;
        chk("busy_end", {31'b0, busy}, 0);
        chk("valid_end", {31'b0, out_valid}, 0);
        chk("in_ready_end", {31'b0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [9:0]  s10;
        logic [15:0] d16;
        int s, l;
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_idle_outputs("reset");
        @(posedge clk); #1;

        send(mk_write(10'd5, 16'hBEEF));
        send(mk_range(10'd5, 10'd5));
        send(mk_go());
        burst(0, 0, 1'b0);

        for (int i = 0; i < 8; i++) send(mk_write(10'(i), 16'(i)));
        send(mk_range(10'd0, 10'd7));
        send(mk_go());
        burst(0, 0, 1'b0);

        send(mk_write(10'd1022, 16'hA));
        send(mk_write(10'd1023, 16'hB));
        send(mk_write(10'd0, 16'hC));
        send(mk_write(10'd1, 16'hD));
        send(mk_range(10'd1022, 10'd1));
        send(mk_go());
        burst(0, 0, 1'b0);

        for (int i = 0; i < 8; i++) send(mk_write(10'(i), 16'(i)));
        send(mk_range(10'd0, 10'd7));
        send(mk_go());
        burst(1, 0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            d16 = 16'($urandom);
            send(mk_write(10'(i), d16));
        end
        send(mk_range(10'd0, 10'd15));
        send(mk_go());
        burst(0, 3, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b0;
        r_start = 0;
        r_end   = 0;
        #1 check_idle_outputs("midreset");
        @(posedge clk); #1;
        send(mk_go());
        burst(0, 0, 1'b0);

        for (int i = 0; i < 1024; i++) begin
            d16 = 16'($urandom);
            send(mk_write(10'(i), d16));
        end
        send(mk_range(10'd0, 10'd1023));
        send(mk_go());
        burst(0, 0, 1'b1);

        for (int r = 0; r < 20; r++) begin
            l = $urandom_range(0, 3);
            for (int i = 0; i < l; i++) begin
                s10 = 10'($urandom);
                d16 = 16'($urandom);
                send(mk_write(s10, d16));
            end
            if ($urandom_range(0, 3) == 0) send(mk_nop());
            s = $urandom_range(0, 1023);
            l = $urandom_range(1, 24);
            send(mk_range(10'(s), 10'((s + l - 1) % 1024)));
            send(mk_go());
            burst(2, 0, 1'b0);
        end

        chk("we_count", we_cnt, writes_sent);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
